// File: rtl/counter_monitor_if.sv
// Observation bus between the up/down counter under test and counter_monitor.
// The harness drives the master side; the monitor implements the slave side.
interface counter_monitor_if #(
    parameter int WIDTH = 8
);
    logic             sample_en;
    logic [WIDTH-1:0] count_in;
    logic             err_clr;
    logic [1:0]       step;
    logic             step_vld;
    logic [1:0]       dir;
    logic [7:0]       run_len;
    logic             wrap_up;
    logic             wrap_dn;
    logic [7:0]       wrap_cnt;
    logic             err;

    modport master (
        output sample_en, count_in, err_clr,
        input  step, step_vld, dir, run_len, wrap_up, wrap_dn, wrap_cnt, err
    );

    modport slave (
        input  sample_en, count_in, err_clr,
        output step, step_vld, dir, run_len, wrap_up, wrap_dn, wrap_cnt, err
    );
endinterface

// File: rtl/counter_monitor.sv
// Observer for an up/down counter: classifies each sample as hold/up/down/illegal.
// Wrap detection (wrap_up, wrap_dn, wrap_cnt) is built only when COUNTER_MONITOR_WRAP_EN is defined.
module counter_monitor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    counter_monitor_if.slave  mon
);

    // Low two bits of each state are the externally visible dir code.
    typedef enum logic [2:0] {
        S_PRIME = 3'b000,
        S_HOLD  = 3'b001,
        S_UP    = 3'b010,
        S_DOWN  = 3'b011,
        S_FAULT = 3'b100
    } state_e;

    localparam logic [1:0] CLS_HOLD = 2'b00;
    localparam logic [1:0] CLS_UP   = 2'b01;
    localparam logic [1:0] CLS_DOWN = 2'b10;
    localparam logic [1:0] CLS_ILL  = 2'b11;

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [1:0]       step_q, step_d;
    logic             step_vld_q, step_vld_d;
    logic [7:0]       run_len_q, run_len_d;
    logic             err_q, err_d;
    logic             first_q, first_d;

    logic [WIDTH-1:0] delta_s;
    logic [1:0]       cls_s;
    state_e           cls_state_s;
    logic             tracking_s;

    assign delta_s    = mon.count_in - prev_q;
    assign tracking_s = mon.sample_en &&
                        ((state_q == S_HOLD) || (state_q == S_UP) || (state_q == S_DOWN));

    // Map the modular delta to a step class and its tracking state.
    always_comb begin
        cls_s       = CLS_ILL;
        cls_state_s = S_FAULT;
        if (delta_s == ALL_ZERO) begin
            cls_s       = CLS_HOLD;
            cls_state_s = S_HOLD;
        end else if (delta_s == ONE) begin
            cls_s       = CLS_UP;
            cls_state_s = S_UP;
        end else if (delta_s == ALL_ONES) begin
            cls_s       = CLS_DOWN;
            cls_state_s = S_DOWN;
        end else begin
            cls_s       = CLS_ILL;
            cls_state_s = S_FAULT;
        end
    end

    // Next-state and next-output computation for the classifier FSM.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        step_d     = step_q;
        step_vld_d = 1'b0;
        run_len_d  = run_len_q;
        first_d    = first_q;
        // A simultaneous illegal step overrides the clear below.
        err_d      = mon.err_clr ? 1'b0 : err_q;

        if (mon.sample_en) begin
            case (state_q)
                S_PRIME, S_FAULT: begin
                    prev_d  = mon.count_in;
                    state_d = S_HOLD;
                    first_d = 1'b1;
                end
                S_HOLD, S_UP, S_DOWN: begin
                    prev_d     = mon.count_in;
                    step_d     = cls_s;
                    step_vld_d = 1'b1;
                    first_d    = 1'b0;
                    state_d    = cls_state_s;
                    if (cls_s == CLS_ILL) begin
                        err_d     = 1'b1;
                        run_len_d = 8'd0;
                    end else if (first_q || (cls_state_s != state_q)) begin
                        run_len_d = 8'd1;
                    end else if (run_len_q != 8'hFF) begin
                        run_len_d = run_len_q + 8'd1;
                    end else begin
                        run_len_d = run_len_q;
                    end
                end
                default: begin
                    state_d = S_PRIME;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Classifier FSM state and its registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_PRIME;
            prev_q     <= ALL_ZERO;
            step_q     <= 2'b00;
            step_vld_q <= 1'b0;
            run_len_q  <= 8'd0;
            err_q      <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            step_q     <= step_d;
            step_vld_q <= step_vld_d;
            run_len_q  <= run_len_d;
            err_q      <= err_d;
            first_q    <= first_d;
        end
    end

    assign mon.step     = step_q;
    assign mon.step_vld = step_vld_q;
    assign mon.dir      = state_q[1:0];
    assign mon.run_len  = run_len_q;
    assign mon.err      = err_q;

`ifdef COUNTER_MONITOR_WRAP_EN
    logic       wrap_up_q, wrap_up_d;
    logic       wrap_dn_q, wrap_dn_d;
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    // Wrap events are only recognised on classified up/down steps.
    always_comb begin
        wrap_up_d  = 1'b0;
        wrap_dn_d  = 1'b0;
        wrap_cnt_d = wrap_cnt_q;
        if (tracking_s && (cls_s == CLS_UP) &&
            (prev_q == ALL_ONES) && (mon.count_in == ALL_ZERO)) begin
            wrap_up_d = 1'b1;
        end else if (tracking_s && (cls_s == CLS_DOWN) &&
                     (prev_q == ALL_ZERO) && (mon.count_in == ALL_ONES)) begin
            wrap_dn_d = 1'b1;
        end else begin
            wrap_up_d = 1'b0;
            wrap_dn_d = 1'b0;
        end
        if ((wrap_up_d || wrap_dn_d) && (wrap_cnt_q != 8'hFF)) begin
            wrap_cnt_d = wrap_cnt_q + 8'd1;
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end
    end

    // Wrap pulse and saturating wrap counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_up_q  <= 1'b0;
            wrap_dn_q  <= 1'b0;
            wrap_cnt_q <= 8'd0;
        end else begin
            wrap_up_q  <= wrap_up_d;
            wrap_dn_q  <= wrap_dn_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign mon.wrap_up  = wrap_up_q;
    assign mon.wrap_dn  = wrap_dn_q;
    assign mon.wrap_cnt = wrap_cnt_q;
`else
    assign mon.wrap_up  = 1'b0;
    assign mon.wrap_dn  = 1'b0;
    assign mon.wrap_cnt = 8'd0;
`endif

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Checker that observes the 8-bit output of the up/down counter and recovers the behaviour that produced it: each sampled value is classified as a hold, count-up or count-down step relative to the previous sample. Any other jump is flagged as illegal. Sits beside the counter in the Ex3 bench and system top as a self-checking observer. It also reports direction, run length, wrap events and a sticky error to the test harness.

## Interface
- `WIDTH`, 8, width of the observed count.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous reset, active-high.
- `sample_en`  in  1  when 1, `count_in` is sampled this edge; when 0, all state and outputs hold.
- `count_in`  in  WIDTH  observed counter value.
- `err_clr`  in  1  clears sticky `err` (synchronous).
- `step`  out  2  class of the last classified step: 00 hold, 01 up, 10 down, 11 illegal.
- `step_vld`  out  1  one-cycle pulse: `step` was updated this cycle.
- `dir`  out  2  FSM state encoding (see Operation).
- `run_len`  out  8  consecutive steps of the current class, saturating at 255.
- `wrap_up`  out  1  one-cycle pulse on an up step from all-ones to 0.
- `wrap_dn`  out  1  one-cycle pulse on a down step from 0 to all-ones.
- `wrap_cnt`  out  8  total wrap events, saturating at 255.
- `err`  out  1  sticky illegal-step flag.

## Operation
- The block stores the previous sample `prev`. Delta is `count_in - prev` modulo 2^WIDTH:
  - 0 → hold.
  - 1 → up.
  - all-ones → down.
  - any other value → illegal.
- FSM states: PRIME (00), HOLD/UP/DOWN tracking (`dir` = 01 hold, 10 up, 11 down), FAULT (`dir` = 00, internal flag distinguishes it from PRIME).
- PRIME: the first `sample_en` after reset or FAULT only loads `prev`. No classification, no `step_vld`. The FSM then moves to HOLD.
- Tracking states: each sample is classified and `prev` is updated.
  - A legal class moves the FSM to the matching state.
  - Illegal sets `err`, drives `step`=11, and moves the FSM to FAULT.
- FAULT: the next sample loads `prev` with no classification (resync) and returns the FSM to HOLD. `step_vld` stays 0 for that sample.
- `run_len`:
  - Set to 1 when the class differs from the previous class, or on the first classified step after PRIME or FAULT.
  - Otherwise incremented, saturating at 255.
  - Illegal steps force `run_len` to 0.
- Wrap detection:
  - Up with `prev`=all-ones and `count_in`=0 pulses `wrap_up`.
  - Down with `prev`=0 and `count_in`=all-ones pulses `wrap_dn`.
  - Either event increments `wrap_cnt`.
- `err` is set on illegal and cleared by `err_clr`. If both happen in the same cycle, set wins.

## Timing
- All outputs are registered. Results appear the cycle after the `sample_en` edge, i.e. 1-cycle latency.
- Reset values: `step`=00, `step_vld`=0, `dir`=00 (PRIME), `run_len`=0, `wrap_up`=0, `wrap_dn`=0, `wrap_cnt`=0, `err`=0, `prev`=0.
- Asserting reset mid-run returns the FSM to PRIME immediately. The first post-reset sample is never classified.
- `sample_en`=0 freezes everything and clears the pulse outputs (`step_vld`, `wrap_up`, `wrap_dn`).
- `err_clr` acts regardless of `sample_en`.

## Configuration
- `COUNTER_MONITOR_WRAP_EN` defined: wrap detection, `wrap_up`, `wrap_dn` and `wrap_cnt` are implemented as described.
- Not defined: wrap logic is removed and these three outputs are tied to 0. Classification of wrap steps as up/down is unchanged.

## Test plan
- Reset, then sample 5,6,7,8 → first sample has no `step_vld`. Next three give `step`=01, `dir`=10, `run_len` 1,2,3.
- Sample 2,1,0,255 → `step`=10 each time, `wrap_dn` pulses on 255, `wrap_cnt`=1 (0 with macro undefined).
- Sample 9,9,10 → hold with `run_len`=1 then 2, then up with `run_len`=1, `dir`=10.
- Sample 10 then 40 → `step`=11, `err`=1, `run_len`=0, FSM FAULT. Then 41 (resync, no `step_vld`), then 42 gives up with `run_len`=1. `err` stays 1 until `err_clr`.
- Illegal step and `err_clr` in the same cycle → `err` remains 1.
- Assert `rst` between samples 100 and 101 → all outputs return to reset values. Sample 101 only primes.
